pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline-boundary register, the successor to the fixed 64-bit fetch/decode latch.
- Carries an arbitrary payload with a valid bit, plus stall, flush and a `FLUSH_VAL` bubble image.
- Has an optional one-entry skid buffer, so a synchronous-read instruction memory never loses a word while the stage is stalled.
- Has a saturating stall-cycle counter for performance analysis.
- Instantiated at IF/ID (with skid) and at ID/EX, EX/MEM and MEM/WB (without skid).

Parameters:
- `DATA_W`, 64, payload width in bits (PC concatenated with instruction at IF/ID).
- `FLUSH_VAL`, 0, payload value loaded on reset and on flush; all-zero encodes a MIPS NOP.
- `SKID_EN`, 1, 1 instantiates the skid entry; 0 means no skid storage.
- `CNT_W`, 16, width of the stall-cycle counter.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream word present on `in_data`.
- `in_data`  in  `DATA_W`  upstream payload.
- `in_ready`  out  1  stage accepts `in_data` this cycle.
- `stall`  in  1  downstream holds; output must not change while `out_valid`=1.
- `flush`  in  1  discard all held words (branch or jump taken).
- `out_valid`  out  1  `out_data` holds a real instruction.
- `out_data`  out  `DATA_W`  registered payload to the next stage.
- `stall_cnt`  out  `CNT_W`  cycles with `stall`=1 and `out_valid`=1, saturating.

Behaviour:
- **Reset** (async, immediate, independent of clock):
  - `out_valid`=0, `out_data`=`FLUSH_VAL`.
  - skid_valid=0, skid_data=`FLUSH_VAL`.
  - `stall_cnt`=0.
- **Priority at each rising edge:** reset > flush > advance/hold.
- **Flush:**
  - `out_valid`<=0, `out_data`<=`FLUSH_VAL`, skid_valid<=0.
  - `in_data` is dropped even if `in_valid`=1.
  - Flush overrides a simultaneous stall.
- **`in_ready` (combinational):**
  - `SKID_EN`=1: `in_ready` = !skid_valid.
  - `SKID_EN`=0: `in_ready` = !stall | !`out_valid`.
  - `in_ready` never depends on `flush`.
- **Advance** (`stall`=0, or `out_valid`=0, i.e. the output slot is free or bubble-filled):
  - If skid_valid=1: `out_data`<=skid_data, `out_valid`<=1, skid_valid<=0. Input is not accepted this cycle because `in_ready`=0.
  - Else: `out_data`<=`in_data`, `out_valid`<=`in_valid`.
  - When `in_valid`=0, `out_data` is don't-care but is still loaded (no enable gating required).
- **Hold** (`stall`=1 and `out_valid`=1):
  - `out_data` and `out_valid` are unchanged.
  - If `SKID_EN`=1, `in_valid`=1 and skid_valid=0: skid_data<=`in_data`, skid_valid<=1.
- **Bubble collapse:** `stall`=1 with `out_valid`=0 loads a new word. Stalling a bubble is never a hold.
- **Ordering:** words leave in acceptance order. No word is duplicated. No accepted word is lost except by flush.
- **Latency:** 1 cycle from acceptance to `out_valid` when no skid word is pending; 2 cycles when routed via skid.
- **`stall_cnt`:**
  - Increments by 1 on every edge with `stall`=1 and `out_valid`=1.
  - Saturates at 2^`CNT_W`-1.
  - Cleared only by reset, not by flush.
- **No-skid build:** with `SKID_EN`=0, the skid register and its logic must be absent; skid_valid is treated as constant 0.

Decomposition:
- Shared package `pipe_pkg`:
  - `ZERO_WORD` (32'h0), `NOP_INSTR`.
  - IF/ID payload field offsets `PL_PC_LSB` and `PL_INSTR_LSB`, so all stages slice `out_data` identically.
- One natural sub-module: `sat_counter` (width-parametrised, enable plus async reset, saturating), used for `stall_cnt`.
- Skid logic stays inline, under a generate on `SKID_EN`.

Test Plan:
1. Reset mid-stream: with `out_valid`=1 and skid_valid=1, pulse `reset` between clock edges.
   - `out_valid`=0, `out_data`=0 and `stall_cnt`=0 immediately (before the next edge).
   - `in_ready`=1 after release.
2. Stall with skid (`SKID_EN`=1): stream A=0x...100, B=0x...104, C=0x...108 with `in_valid`=1; raise `stall` for 3 cycles while A is on the output.
   - `out_data`=A is held; B is captured in skid.
   - `in_ready`=0 while stalled; C is held upstream.
   - After `stall` drops, output is A, B, C on consecutive cycles.
   - `stall_cnt`=3.
3. Flush during stall: `stall`=1, skid holds B, then `flush`=1 with `in_valid`=1 (D).
   - Next cycle `out_valid`=0, `out_data`=`FLUSH_VAL`, skid empty.
   - D is not presented; `stall_cnt` is unchanged.
4. Bubble collapse: `out_valid`=0, `stall`=1, `in_valid`=1 with E.
   - After one edge, `out_valid`=1 and `out_data`=E.
   - `stall_cnt` does not increment on that edge.
5. No-skid build (`SKID_EN`=0, `DATA_W`=32): while `stall`=1 and `out_valid`=1, `in_ready`=0 and the output is held.
   - Consecutive acceptances continue at 1 word per cycle after `stall` drops.
6. Counter saturation (`CNT_W`=4): hold `stall`=1 with `out_valid`=1 for 20 cycles.
   - `stall_cnt` reads 15 and stays at 15.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: NOP encoding and IF/ID payload layout.
// Every stage slices out_data through these offsets.
package pipe_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  // sll $0,$0,0 is the all-zero word, so a zero payload is a MIPS NOP.
  localparam logic [31:0] NOP_INSTR = ZERO_WORD;

  localparam int PL_INSTR_LSB = 0;
  localparam int PL_PC_LSB    = 32;
  localparam int IFID_W       = 64;

  function automatic logic [IFID_W-1:0] make_ifid(input logic [31:0] pc,
                                                  input logic [31:0] instr);
    logic [IFID_W-1:0] w;
    w = '0;
    w[PL_PC_LSB +: 32]    = pc;
    w[PL_INSTR_LSB +: 32] = instr;
    return w;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline-boundary register.
// The stage itself takes the slave view; the surrounding pipeline takes master.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, stall, flush,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, stall, flush,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Width-parametrised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register with flush bubble, optional one-entry skid
// buffer and a saturating count of stalled cycles.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = IFID_W,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int                SKID_EN   = 1,
  parameter int                CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  pipe_stage_reg_if.slave  link,
  output logic [CNT_W-1:0] stall_cnt
);

  logic              held_valid;
  logic [DATA_W-1:0] held_data;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              hold;

  // A stalled bubble is not a hold: the empty slot is refilled regardless.
  assign hold = link.stall & held_valid;

  generate
    if (SKID_EN != 0) begin : g_skid
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          skid_valid <= 1'b0;
          skid_data  <= FLUSH_VAL;
        end else if (link.flush) begin
          skid_valid <= 1'b0;
        end else if (!hold) begin
          skid_valid <= 1'b0;
        end else if (link.in_valid && !skid_valid) begin
          skid_valid <= 1'b1;
          skid_data  <= link.in_data;
        end
      end

      assign link.in_ready = !skid_valid;
    end else begin : g_no_skid
      assign skid_valid    = 1'b0;
      assign skid_data     = FLUSH_VAL;
      assign link.in_ready = !link.stall | !held_valid;
    end
  endgenerate

  // A pending skid word always leaves before anything new, preserving order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_valid <= 1'b0;
      held_data  <= FLUSH_VAL;
    end else if (link.flush) begin
      held_valid <= 1'b0;
      held_data  <= FLUSH_VAL;
    end else if (!hold) begin
      if (skid_valid) begin
        held_valid <= 1'b1;
        held_data  <= skid_data;
      end else begin
        held_valid <= link.in_valid;
        held_data  <= link.in_data;
      end
    end
  end

  assign link.out_valid = held_valid;
  assign link.out_data  = held_data;

  // Flush wins over a simultaneous stall, so that edge is not counted.
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .en    (hold & !link.flush),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid build and a narrow no-skid build driven in
// lockstep, each compared against a queue model of the words in flight.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam logic [31:0] FLUSH_B = 32'hDEAD_BEEF;

  logic clock;
  logic reset;
  logic [15:0] cnt_obs_a;
  logic [3:0]  cnt_obs_b;

  pipe_stage_reg_if #(.DATA_W(64)) ifa ();
  pipe_stage_reg_if #(.DATA_W(32)) ifb ();

  pipe_stage_reg #(
    .DATA_W(64), .FLUSH_VAL(64'h0), .SKID_EN(1), .CNT_W(16)
  ) dut_a (
    .clock(clock), .reset(reset), .link(ifa), .stall_cnt(cnt_obs_a)
  );

  pipe_stage_reg #(
    .DATA_W(32), .FLUSH_VAL(FLUSH_B), .SKID_EN(0), .CNT_W(4)
  ) dut_b (
    .clock(clock), .reset(reset), .link(ifb), .stall_cnt(cnt_obs_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: words held by the stage, oldest (the one on out_data) first.
  logic [63:0] qa[$];
  logic [31:0] qb[$];
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic exp_rdy_a, exp_rdy_b, obs_rdy_a, obs_rdy_b;

  task automatic model_clear(input bit clear_counts);
    qa.delete();
    qb.delete();
    if (clear_counts) begin
      cnt_a = '0;
      cnt_b = '0;
    end
  endtask

  // One clock: drive, capture in_ready before the edge, advance the model.
  task automatic tick(input logic v, input logic [63:0] d, input logic s, input logic f);
    ifa.in_valid = v; ifa.in_data = d;       ifa.stall = s; ifa.flush = f;
    ifb.in_valid = v; ifb.in_data = d[31:0]; ifb.stall = s; ifb.flush = f;
    #1;
    exp_rdy_a = (qa.size() < 2);
    exp_rdy_b = !s || (qb.size() == 0);
    obs_rdy_a = ifa.in_ready;
    obs_rdy_b = ifb.in_ready;
    @(posedge clock);
    if (f) begin
      model_clear(1'b0);
    end else begin
      if (s && qa.size() != 0 && cnt_a != 16'hFFFF) cnt_a = cnt_a + 16'd1;
      if (s && qb.size() != 0 && cnt_b != 4'hF) cnt_b = cnt_b + 4'd1;
      if (!s && qa.size() != 0) void'(qa.pop_front());
      if (!s && qb.size() != 0) void'(qb.pop_front());
      if (v && exp_rdy_a) qa.push_back(d);
      if (v && exp_rdy_b) qb.push_back(d[31:0]);
    end
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] wa, wb;
    wa = make_ifid(32'h0000_0100, 32'h8C01_0100);
    wb = make_ifid(32'h0000_0104, 32'h8C01_0104);
    reset = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.stall = 1'b0; ifa.flush = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.stall = 1'b0; ifb.flush = 1'b0;
    #3;
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL por_valid_a: got %b want 0", ifa.out_valid); end
    n_cmp++; if (ifa.out_data !== 64'h0) begin n_fail++; $display("[TB] FAIL por_data_a: got %h want 0", ifa.out_data); end
    n_cmp++; if (cnt_obs_a !== 16'h0) begin n_fail++; $display("[TB] FAIL por_cnt_a: got %0d want 0", cnt_obs_a); end
    n_cmp++; if (ifb.out_data !== FLUSH_B) begin n_fail++; $display("[TB] FAIL por_data_b: got %h want %h", ifb.out_data, FLUSH_B); end
    #9 reset = 1'b0;
    model_clear(1'b1);

    // Fill the output and the skid entry, then reset between edges.
    tick(1'b1, wa, 1'b0, 1'b0);
    tick(1'b1, wb, 1'b1, 1'b0);
    n_cmp++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_valid_a: got %b want 1", ifa.out_valid); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_valid_a: got %b want 0", ifa.out_valid); end
    n_cmp++; if (ifa.out_data !== 64'h0) begin n_fail++; $display("[TB] FAIL mid_reset_data_a: got %h want 0", ifa.out_data); end
    n_cmp++; if (cnt_obs_a !== 16'h0) begin n_fail++; $display("[TB] FAIL mid_reset_cnt_a: got %0d want 0", cnt_obs_a); end
    n_cmp++; if (cnt_obs_b !== 4'h0) begin n_fail++; $display("[TB] FAIL mid_reset_cnt_b: got %0d want 0", cnt_obs_b); end
    n_cmp++; if (ifb.out_data !== FLUSH_B) begin n_fail++; $display("[TB] FAIL mid_reset_data_b: got %h want %h", ifb.out_data, FLUSH_B); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ready_a: got %b want 1", ifa.in_ready); end
    n_cmp++; if (ifb.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ready_b: got %b want 1", ifb.in_ready); end
    model_clear(1'b1);
  endtask

  task automatic test_stall_skid();
    logic [63:0] wa, wb, wc;
    wa = make_ifid(32'h0000_0100, 32'h2001_0100);
    wb = make_ifid(32'h0000_0104, 32'h2001_0104);
    wc = make_ifid(32'h0000_0108, 32'h2001_0108);
    tick(1'b0, 64'h0, 1'b0, 1'b1);
    tick(1'b1, wa, 1'b0, 1'b0);
    n_cmp++; if (ifa.out_data !== wa) begin n_fail++; $display("[TB] FAIL skid_first_a: got %h want %h", ifa.out_data, wa); end
    tick(1'b1, wb, 1'b1, 1'b0);
    n_cmp++; if (ifa.out_data !== wa) begin n_fail++; $display("[TB] FAIL skid_hold1_a: got %h want %h", ifa.out_data, wa); end
    tick(1'b1, wc, 1'b1, 1'b0);
    n_cmp++; if (obs_rdy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL skid_ready_stalled_a: got %b want 0", obs_rdy_a); end
    tick(1'b1, wc, 1'b1, 1'b0);
    n_cmp++; if (ifa.out_data !== wa || ifa.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL skid_hold3_a: got %b/%h want 1/%h", ifa.out_valid, ifa.out_data, wa); end
    tick(1'b1, wc, 1'b0, 1'b0);
    n_cmp++; if (obs_rdy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL skid_ready_drain_a: got %b want 0", obs_rdy_a); end
    n_cmp++; if (ifa.out_data !== wb || ifa.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL skid_second_a: got %b/%h want 1/%h", ifa.out_valid, ifa.out_data, wb); end
    tick(1'b1, wc, 1'b0, 1'b0);
    n_cmp++; if (ifa.out_data !== wc || ifa.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL skid_third_a: got %b/%h want 1/%h", ifa.out_valid, ifa.out_data, wc); end
    tick(1'b0, 64'h0, 1'b0, 1'b0);
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL skid_empty_a: got %b want 0", ifa.out_valid); end
    n_cmp++; if (cnt_obs_a !== 16'd3) begin n_fail++; $display("[TB] FAIL skid_cnt_a: got %0d want 3", cnt_obs_a); end
  endtask

  task automatic test_flush_during_stall();
    logic [63:0] wa, wb, wd;
    wa = make_ifid(32'h0000_0200, 32'h0123_4567);
    wb = make_ifid(32'h0000_0204, 32'h89AB_CDEF);
    wd = make_ifid(32'h0000_0208, 32'h1357_9BDF);
    tick(1'b1, wa, 1'b0, 1'b0);
    tick(1'b1, wb, 1'b1, 1'b0);
    tick(1'b1, wd, 1'b1, 1'b1);
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid_a: got %b want 0", ifa.out_valid); end
    n_cmp++; if (ifa.out_data !== 64'h0) begin n_fail++; $display("[TB] FAIL flush_data_a: got %h want 0", ifa.out_data); end
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_skid_empty_a: got %b want 1", ifa.in_ready); end
    n_cmp++; if (cnt_obs_a !== 16'd4) begin n_fail++; $display("[TB] FAIL flush_cnt_a: got %0d want 4", cnt_obs_a); end
    n_cmp++; if (ifb.out_valid !== 1'b0 || ifb.out_data !== FLUSH_B) begin n_fail++; $display("[TB] FAIL flush_b: got %b/%h want 0/%h", ifb.out_valid, ifb.out_data, FLUSH_B); end
    tick(1'b0, 64'h0, 1'b0, 1'b0);
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_no_d_a: got %b want 0", ifa.out_valid); end
  endtask

  task automatic test_bubble_collapse();
    logic [63:0] we;
    we = make_ifid(32'h0000_0300, 32'hA5A5_5A5A);
    tick(1'b1, we, 1'b1, 1'b0);
    n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== we) begin n_fail++; $display("[TB] FAIL bubble_load_a: got %b/%h want 1/%h", ifa.out_valid, ifa.out_data, we); end
    n_cmp++; if (cnt_obs_a !== 16'd4) begin n_fail++; $display("[TB] FAIL bubble_cnt_a: got %0d want 4", cnt_obs_a); end
    tick(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if (cnt_obs_a !== 16'd5) begin n_fail++; $display("[TB] FAIL bubble_then_stall_cnt_a: got %0d want 5", cnt_obs_a); end
  endtask

  task automatic test_no_skid();
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 32'h4000_0000 + 32'(i * 4);
    tick(1'b0, 64'h0, 1'b0, 1'b1);
    tick(1'b1, {32'h0, w[0]}, 1'b0, 1'b0);
    n_cmp++; if (ifb.out_data !== w[0] || ifb.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL noskid_first_b: got %b/%h want 1/%h", ifb.out_valid, ifb.out_data, w[0]); end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, {32'h0, w[1]}, 1'b1, 1'b0);
      n_cmp++; if (obs_rdy_b !== 1'b0) begin n_fail++; $display("[TB] FAIL noskid_ready_b: got %b want 0", obs_rdy_b); end
      n_cmp++; if (ifb.out_data !== w[0] || ifb.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL noskid_hold_b: got %b/%h want 1/%h", ifb.out_valid, ifb.out_data, w[0]); end
    end
    for (int i = 1; i < 4; i++) begin
      tick(1'b1, {32'h0, w[i]}, 1'b0, 1'b0);
      n_cmp++; if (obs_rdy_b !== 1'b1) begin n_fail++; $display("[TB] FAIL noskid_stream_ready_b: got %b want 1", obs_rdy_b); end
      n_cmp++; if (ifb.out_data !== w[i] || ifb.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL noskid_stream_b: got %b/%h want 1/%h", ifb.out_valid, ifb.out_data, w[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] held;
    held = qb[0];
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 64'h0, 1'b1, 1'b0);
      n_cmp++; if (ifb.out_data !== held || ifb.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_hold_b: got %b/%h want 1/%h", ifb.out_valid, ifb.out_data, held); end
      n_cmp++; if (cnt_obs_b !== cnt_b) begin n_fail++; $display("[TB] FAIL sat_cnt_b: got %0d want %0d", cnt_obs_b, cnt_b); end
    end
    n_cmp++; if (cnt_obs_b !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_final_b: got %0d want 15", cnt_obs_b); end
    n_cmp++; if (cnt_obs_a !== cnt_a) begin n_fail++; $display("[TB] FAIL sat_cnt_a: got %0d want %0d", cnt_obs_a, cnt_a); end
  endtask

  task automatic test_random();
    logic v, s, f;
    logic [63:0] d;
    for (int i = 0; i < 300; i++) begin
      d = {$urandom(), $urandom()};
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 1) != 0);
      f = ($urandom_range(0, 15) == 0);
      tick(v, d, s, f);
      n_cmp++; if (obs_rdy_a !== exp_rdy_a) begin n_fail++; $display("[TB] FAIL rnd_ready_a cyc %0d: got %b want %b", i, obs_rdy_a, exp_rdy_a); end
      n_cmp++; if (obs_rdy_b !== exp_rdy_b) begin n_fail++; $display("[TB] FAIL rnd_ready_b cyc %0d: got %b want %b", i, obs_rdy_b, exp_rdy_b); end
      n_cmp++; if (ifa.out_valid !== (qa.size() != 0)) begin n_fail++; $display("[TB] FAIL rnd_valid_a cyc %0d: got %b want %b", i, ifa.out_valid, qa.size() != 0); end
      n_cmp++; if (ifb.out_valid !== (qb.size() != 0)) begin n_fail++; $display("[TB] FAIL rnd_valid_b cyc %0d: got %b want %b", i, ifb.out_valid, qb.size() != 0); end
      if (qa.size() != 0) begin
        n_cmp++; if (ifa.out_data !== qa[0]) begin n_fail++; $display("[TB] FAIL rnd_data_a cyc %0d: got %h want %h", i, ifa.out_data, qa[0]); end
      end
      if (qb.size() != 0) begin
        n_cmp++; if (ifb.out_data !== qb[0]) begin n_fail++; $display("[TB] FAIL rnd_data_b cyc %0d: got %h want %h", i, ifb.out_data, qb[0]); end
      end
      n_cmp++; if (cnt_obs_a !== cnt_a) begin n_fail++; $display("[TB] FAIL rnd_cnt_a cyc %0d: got %0d want %0d", i, cnt_obs_a, cnt_a); end
      n_cmp++; if (cnt_obs_b !== cnt_b) begin n_fail++; $display("[TB] FAIL rnd_cnt_b cyc %0d: got %0d want %0d", i, cnt_obs_b, cnt_b); end
    end
  endtask

  initial begin
    test_reset();
    test_stall_skid();
    test_flush_during_stall();
    test_bubble_collapse();
    test_no_skid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] time limit expired");
  end

endmodule
